// File: rtl/hazard_unit_sb.sv
// Hazard detection beside ID: load-use interlock plus a single-entry scoreboard
// for the non-pipelined iterative FP divider (RAW, WAW and structural stalls).
module hazard_unit_sb #(
    parameter int REG_ADDR_W = 6,
    parameter int DIV_LAT    = 16,
    parameter int CNT_W      = $clog2(DIV_LAT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic [REG_ADDR_W-1:0] rd_id,
    input  logic                  use_rs1_id,
    input  logic                  use_rs2_id,
    input  logic                  reg_wr_id,
    input  logic                  is_div_id,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic                  mem_rd_ex,
    input  logic                  ext_stall,
    input  logic                  flush,
    output logic                  pc_remain,
    output logic                  reg_if_id_remain,
    output logic                  zero_control,
    output logic                  div_busy,
    output logic                  div_wb,
    output logic [REG_ADDR_W-1:0] div_wb_rd
);

    logic [CNT_W-1:0] count;
    logic             load_use;
    logic             div_raw;
    logic             div_waw;
    logic             div_struct;
    logic             hold;
    logic             issue;

    // Specifier 0 is integer x0 and never hazards; f0 (bit[5]=1) is a real register.
    always_comb begin
        load_use   = mem_rd_ex && (rd_ex != '0) &&
                     ((use_rs1_id && (rs1_id == rd_ex)) ||
                      (use_rs2_id && (rs2_id == rd_ex)));
        div_raw    = div_busy && (div_wb_rd != '0) &&
                     ((use_rs1_id && (rs1_id == div_wb_rd)) ||
                      (use_rs2_id && (rs2_id == div_wb_rd)));
        div_waw    = div_busy && reg_wr_id && (rd_id == div_wb_rd) && (rd_id != '0);
        div_struct = div_busy && is_div_id;
        hold       = load_use || div_raw || div_waw || div_struct || ext_stall;
        issue      = is_div_id && !hold && !flush;
    end

    assign pc_remain        = hold;
    assign reg_if_id_remain = hold;
    assign zero_control     = hold;

    // Derived from registered state only, so the pulse is glitch-free.
    assign div_wb = div_busy && (count == CNT_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_busy  <= 1'b0;
            count     <= '0;
            div_wb_rd <= '0;
        end else if (issue) begin
            // issue cannot coincide with busy: div_struct holds any second divide.
            div_busy  <= 1'b1;
            count     <= CNT_W'(DIV_LAT);
            div_wb_rd <= rd_id;
        end else if (div_busy) begin
            // The divider runs on through ext_stall and flush.
            if (count == CNT_W'(1)) begin
                div_busy <= 1'b0;
                count    <= '0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Directed self-checking bench for hazard_unit_sb: interlocks, divide scoreboard
// timing, flush/stall/reset interaction, and DIV_LAT=2/31 instances.
module tb_hazard_unit_sb;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] rs1_id, rs2_id, rd_id, rd_ex;
    logic       use_rs1_id, use_rs2_id, reg_wr_id, is_div_id;
    logic       mem_rd_ex, ext_stall, flush;
    logic       pc_remain, reg_if_id_remain, zero_control;
    logic       div_busy, div_wb;
    logic [5:0] div_wb_rd;

    logic       sw_issue;
    logic       a_pc, a_ifid, a_zc, a_busy, a_wb;
    logic [5:0] a_rd;
    logic       b_pc, b_ifid, b_zc, b_busy, b_wb;
    logic [5:0] b_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_unit_sb #(.REG_ADDR_W(6), .DIV_LAT(16)) dut (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
        .reg_wr_id(reg_wr_id), .is_div_id(is_div_id),
        .rd_ex(rd_ex), .mem_rd_ex(mem_rd_ex),
        .ext_stall(ext_stall), .flush(flush),
        .pc_remain(pc_remain), .reg_if_id_remain(reg_if_id_remain),
        .zero_control(zero_control),
        .div_busy(div_busy), .div_wb(div_wb), .div_wb_rd(div_wb_rd)
    );

    hazard_unit_sb #(.REG_ADDR_W(6), .DIV_LAT(2)) dut_lat2 (
        .clk(clk), .rst(rst),
        .rs1_id(6'd0), .rs2_id(6'd0), .rd_id(6'd40),
        .use_rs1_id(1'b0), .use_rs2_id(1'b0),
        .reg_wr_id(1'b1), .is_div_id(sw_issue),
        .rd_ex(6'd0), .mem_rd_ex(1'b0),
        .ext_stall(1'b0), .flush(1'b0),
        .pc_remain(a_pc), .reg_if_id_remain(a_ifid), .zero_control(a_zc),
        .div_busy(a_busy), .div_wb(a_wb), .div_wb_rd(a_rd)
    );

    hazard_unit_sb #(.REG_ADDR_W(6), .DIV_LAT(31)) dut_lat31 (
        .clk(clk), .rst(rst),
        .rs1_id(6'd0), .rs2_id(6'd0), .rd_id(6'd40),
        .use_rs1_id(1'b0), .use_rs2_id(1'b0),
        .reg_wr_id(1'b1), .is_div_id(sw_issue),
        .rd_ex(6'd0), .mem_rd_ex(1'b0),
        .ext_stall(1'b0), .flush(1'b0),
        .pc_remain(b_pc), .reg_if_id_remain(b_ifid), .zero_control(b_zc),
        .div_busy(b_busy), .div_wb(b_wb), .div_wb_rd(b_rd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        rs1_id = 0; rs2_id = 0; rd_id = 0; rd_ex = 0;
        use_rs1_id = 0; use_rs2_id = 0; reg_wr_id = 0; is_div_id = 0;
        mem_rd_ex = 0; ext_stall = 0; flush = 0; sw_issue = 0;
    endtask

    function automatic logic [2:0] holds();
        return {pc_remain, reg_if_id_remain, zero_control};
    endfunction

    // Present an fdiv to rd in ID for one edge; returns in cycle 0 after issue.
    task automatic issue_div(input logic [5:0] rd);
        idle();
        is_div_id = 1; reg_wr_id = 1; rd_id = rd;
        tick();
        idle();
    endtask

    int  first_wb;
    int  wb_pulses;
    int  first_a, pulses_a, first_b, pulses_b;

    initial begin
        idle();
        rst = 0;
        #12;
        settle();
        check("reset_busy", div_busy, 0);
        check("reset_wb", div_wb, 0);
        check("reset_wb_rd", div_wb_rd, 0);
        check("reset_hold", holds(), 3'b000);
        rst = 1;
        tick();

        // Load-use interlock
        mem_rd_ex = 1; rd_ex = 5; rs1_id = 5; use_rs1_id = 1;
        settle(); check("lu_rs1", holds(), 3'b111);
        rd_ex = 0; rs1_id = 0;
        settle(); check("lu_x0", holds(), 3'b000);
        rd_ex = 32; rs1_id = 0; rs2_id = 32; use_rs1_id = 0; use_rs2_id = 1;
        settle(); check("lu_f0_rs2", holds(), 3'b111);
        use_rs2_id = 0;
        settle(); check("lu_no_use", holds(), 3'b000);
        mem_rd_ex = 0; use_rs2_id = 1;
        settle(); check("lu_not_load", holds(), 3'b000);
        idle(); ext_stall = 1;
        settle(); check("ext_stall_hold", holds(), 3'b111);
        idle();

        // Divide RAW: issue rd=33, dependent rs2=33 held through cycle 15
        tick();
        issue_div(6'd33);
        use_rs2_id = 1; rs2_id = 33;
        first_wb = -1; wb_pulses = 0;
        for (int k = 0; k < 16; k++) begin
            settle();
            check($sformatf("raw_hold_c%0d", k), holds(), 3'b111);
            check($sformatf("raw_busy_c%0d", k), div_busy, 1);
            if (div_wb) begin
                wb_pulses++;
                if (first_wb < 0) first_wb = k;
            end
            tick();
        end
        settle();
        check("raw_wb_cycle", first_wb, 15);
        check("raw_wb_pulses", wb_pulses, 1);
        check("raw_release_hold", holds(), 3'b000);
        check("raw_release_busy", div_busy, 0);
        check("raw_wb_rd_kept", div_wb_rd, 33);

        // WAW then structural: second fdiv rd=40 waits, then issues
        issue_div(6'd33);
        reg_wr_id = 1; rd_id = 33;
        settle(); check("waw_hold", holds(), 3'b111);
        rd_id = 34;
        settle(); check("waw_other_rd", holds(), 3'b000);
        is_div_id = 1; rd_id = 40;
        for (int k = 0; k < 16; k++) begin
            settle();
            check($sformatf("struct_hold_c%0d", k), holds(), 3'b111);
            tick();
        end
        settle();
        check("struct_release", holds(), 3'b000);
        check("struct_busy_clear", div_busy, 0);
        tick();
        idle();
        settle();
        check("struct_issued", div_busy, 1);
        check("struct_wb_rd", div_wb_rd, 40);
        first_wb = -1; wb_pulses = 0;
        for (int k = 0; k < 20; k++) begin
            if (div_wb) begin
                wb_pulses++;
                if (first_wb < 0) first_wb = k;
            end
            tick(); settle();
        end
        check("struct_wb_cycle", first_wb, 15);
        check("struct_wb_pulses", wb_pulses, 1);

        // Flush suppresses issue
        is_div_id = 1; reg_wr_id = 1; rd_id = 35; flush = 1;
        tick(); idle(); settle();
        check("flush_no_issue", div_busy, 0);

        // ext_stall and flush during a divide do not delay writeback
        issue_div(6'd36);
        ext_stall = 1;
        first_wb = -1; wb_pulses = 0;
        for (int k = 0; k < 20; k++) begin
            flush = k[0];
            settle();
            if (k == 3) check("stall_hold", holds(), 3'b111);
            if (div_wb) begin
                wb_pulses++;
                if (first_wb < 0) first_wb = k;
            end
            tick();
        end
        idle(); settle();
        check("stall_wb_cycle", first_wb, 15);
        check("stall_wb_pulses", wb_pulses, 1);

        // Reset mid-divide at count=7 (cycle 9)
        issue_div(6'd37);
        for (int k = 0; k < 9; k++) tick();
        settle();
        check("rst_pre_busy", div_busy, 1);
        rst = 0;
        settle();
        check("rst_async_busy", div_busy, 0);
        check("rst_async_wb", div_wb, 0);
        check("rst_async_rd", div_wb_rd, 0);
        tick();
        rst = 1;
        wb_pulses = 0;
        for (int k = 0; k < 20; k++) begin
            settle();
            if (div_wb || div_busy) wb_pulses++;
            tick();
        end
        check("rst_no_wb", wb_pulses, 0);

        // Latency sweep: DIV_LAT=2 and DIV_LAT=31
        sw_issue = 1;
        tick();
        sw_issue = 0;
        first_a = -1; pulses_a = 0; first_b = -1; pulses_b = 0;
        for (int k = 0; k < 34; k++) begin
            settle();
            if (a_wb) begin pulses_a++; if (first_a < 0) first_a = k; end
            if (b_wb) begin pulses_b++; if (first_b < 0) first_b = k; end
            tick();
        end
        check("lat2_wb_cycle", first_a, 1);
        check("lat2_wb_pulses", pulses_a, 1);
        check("lat31_wb_cycle", first_b, 30);
        check("lat31_wb_pulses", pulses_b, 1);
        check("lat31_wb_rd", b_rd, 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit_sb.md
Name: hazard_unit_sb

Overview:
Parametrised hazard detection unit for the 5-stage RISC-V pipeline with the single-precision FPU. It combines the classic load-use interlock with a single-entry scoreboard that tracks the in-flight iterative FP divide. It also handles RAW, WAW and structural hazards against the divider for a configurable latency. The block sits beside the ID stage and drives the PC hold, the IF/ID hold and the control-zeroing (bubble) signal.

Parameters:
REG_ADDR_W, 6, register specifier width; bit[5]=1 selects the FP file, 0 the integer file
DIV_LAT, 16, FP divide latency in cycles from issue to writeback, must be >= 2
CNT_W, $clog2(DIV_LAT+1), width of the divide countdown counter

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-low reset
rs1_id  in  REG_ADDR_W  source 1 of the instruction in ID
rs2_id  in  REG_ADDR_W  source 2 of the instruction in ID
rd_id  in  REG_ADDR_W  destination of the instruction in ID
use_rs1_id  in  1  ID instruction really reads rs1
use_rs2_id  in  1  ID instruction really reads rs2
reg_wr_id  in  1  ID instruction writes rd_id
is_div_id  in  1  ID instruction is fdiv.s
rd_ex  in  REG_ADDR_W  destination of the instruction in EX
mem_rd_ex  in  1  EX instruction is a load
ext_stall  in  1  stall request from the cache/memory
flush  in  1  branch-mispredict flush of the ID instruction
pc_remain  out  1  hold PC
reg_if_id_remain  out  1  hold IF/ID register
zero_control  out  1  zero ID control signals (insert a bubble)
div_busy  out  1  divide in flight
div_wb  out  1  one-cycle pulse in the divide writeback cycle
div_wb_rd  out  REG_ADDR_W  destination of the in-flight divide

Behaviour:
- Reset (rst=0, asynchronous): div_busy=0, count=0, div_wb_rd=0, div_wb=0. Hold outputs follow the combinational equations with busy=0.
- x0 rule: specifier 0 (integer x0) never creates a hazard. Specifier 32 (f0) is a real register.
- load_use = mem_rd_ex & rd_ex!=0 & ((use_rs1_id & rs1_id==rd_ex) | (use_rs2_id & rs2_id==rd_ex)).
- div_raw = div_busy & div_wb_rd!=0 & ((use_rs1_id & rs1_id==div_wb_rd) | (use_rs2_id & rs2_id==div_wb_rd)).
- div_waw = div_busy & reg_wr_id & rd_id==div_wb_rd & rd_id!=0.
- div_struct = div_busy & is_div_id. The divider is non-pipelined; the writeback cycle still counts as busy, so there is no back-to-back overlap.
- hold = load_use | div_raw | div_waw | div_struct | ext_stall.
- pc_remain = reg_if_id_remain = zero_control = hold. These are combinational, with zero latency in the same cycle.
- Issue: issue = is_div_id & !hold & !flush. On the clk edge it sets div_busy=1, count=DIV_LAT and div_wb_rd=rd_id.
- Countdown: while div_busy, count decrements every cycle, including cycles with ext_stall or flush, because the divider runs independently.
- div_wb = div_busy & count==1, registered-state-derived, so it is glitch-free. On the following edge div_busy=0 and count=0. div_wb_rd holds its value until the next issue.
- Timing: an issue at edge N gives div_wb high in cycle N+DIV_LAT-1 and busy clear from edge N+DIV_LAT. A dependent instruction in ID is released in the cycle after div_wb.
- Flush: a flush never cancels an in-flight divide. It only suppresses a new issue.
- Reset mid-divide: the scoreboard is abandoned immediately and div_wb is never asserted.
- Simultaneous hazards: any hazard term alone is sufficient. There is no priority between them and no double-counting.

Test Plan:
- Load-use: mem_rd_ex=1, rd_ex=5, rs1_id=5, use_rs1_id=1 -> all three hold outputs =1 in the same cycle. With rd_ex=0 -> all =0.
- Divide RAW, DIV_LAT=16: issue fdiv with rd_id=33 at edge 0, then present rs2_id=33 in ID -> hold=1 through cycle 15. div_wb=1 only in cycle 15. hold=0 in cycle 16, div_busy=0.
- WAW and structural: while busy with rd=33, an ID write to 33 -> hold=1. A second is_div_id -> hold=1 until busy clears, then it issues and count=16.
- Flush and ext_stall: is_div_id with flush=1 -> no issue, div_busy stays 0. Holding ext_stall=1 during a divide -> div_wb still arrives exactly DIV_LAT-1 cycles after issue.
- Reset mid-op: drive rst=0 at count=7 -> div_busy=0 asynchronously, and no div_wb pulse after release.
- Parameter sweep: DIV_LAT=2 and DIV_LAT=31 -> div_wb at issue+1 and issue+30 respectively.
